regfile_wb_ctrl: RTL and testbench

Write-back controller driving the integer register file's single write port. Merges one-cycle ALU results with variable-latency load returns, buffering loads in a small queue behind ALU traffic. Keeps a per-register pending-load scoreboard that the ID stage queries for load-use stalls. Sits between EX/MEM and the register file's `wr_en`/`wr_addr`/`wr_data` inputs.

---
 rtl/regfile_wb_ctrl.sv | 114 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back arbiter merging ALU results with queued load returns, plus a pending-load scoreboard
// Optional feature: define WB_LD_BYPASS_EN to let a load skip an empty queue and write one cycle earlier.
module regfile_wb_ctrl #(
    parameter int LQ_DEPTH = 4,
    parameter int XLEN     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [4:0]                  ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    input  logic                        iss_ld_valid,
    input  logic [4:0]                  iss_ld_rd,
    input  logic [4:0]                  rs1_addr,
    input  logic [4:0]                  rs2_addr,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    output logic                        wr_en,
    output logic [4:0]                  wr_addr,
    output logic [XLEN-1:0]             wr_data,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);

    logic [4:0]      q_rd   [LQ_DEPTH];
    logic [XLEN-1:0] q_data [LQ_DEPTH];
    logic [AW-1:0]   rptr, wptr;
    logic [CW-1:0]   count;
    logic [31:0]     pending, pending_n;
    logic            wr_ld;
    logic            alu_win, q_empty, pop, push, byp;

    assign lq_count = count;
    assign ld_ready = count != FULL;
    assign q_empty  = count == '0;
    assign alu_win  = alu_valid && alu_rd != 5'd0;
    assign pop      = !alu_win && !q_empty;
`ifdef WB_LD_BYPASS_EN
    assign byp      = !alu_win && q_empty && ld_valid && ld_rd != 5'd0;
`else
    assign byp      = 1'b0;
`endif
    // x0 loads complete the handshake but are never stored
    assign push     = ld_valid && ld_ready && ld_rd != 5'd0 && !byp;
    assign rs1_busy = pending[rs1_addr];
    assign rs2_busy = pending[rs2_addr];

    // circular load queue; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_rd[wptr]   <= ld_rd;
                q_data[wptr] <= ld_data;
                wptr         <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // output register: ALU first, then queue head, then (optionally) a bypassed load
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_ld   <= 1'b0;
        end else if (alu_win) begin
            wr_en   <= 1'b1;
            wr_addr <= alu_rd;
            wr_data <= alu_data;
            wr_ld   <= 1'b0;
        end else if (pop) begin
            wr_en   <= 1'b1;
            wr_addr <= q_rd[rptr];
            wr_data <= q_data[rptr];
            wr_ld   <= 1'b1;
        end else if (byp) begin
            wr_en   <= 1'b1;
            wr_addr <= ld_rd;
            wr_data <= ld_data;
            wr_ld   <= 1'b1;
        end else begin
            wr_en   <= 1'b0;
            wr_ld   <= 1'b0;
        end
    end

    // scoreboard update: a finishing load write clears, a new issue sets and wins ties
    always_comb begin
        pending_n = pending;
        if (wr_en && wr_ld)
            pending_n[wr_addr] = 1'b0;
        if (iss_ld_valid && iss_ld_rd != 5'd0)
            pending_n[iss_ld_rd] = 1'b1;
        pending_n[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk) begin
        pending <= rst ? '0 : pending_n;
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: randomized and directed checks of regfile_wb_ctrl against a queue-based reference model
module tb_regfile_wb_ctrl;
    localparam int D = 4;
`ifdef WB_LD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic alu_valid = 0, ld_valid = 0, iss_ld_valid = 0;
    logic [4:0] alu_rd = 0, ld_rd = 0, iss_ld_rd = 0, rs1_addr = 0, rs2_addr = 0;
    logic [31:0] alu_data = 0, ld_data = 0;
    logic ld_ready, rs1_busy, rs2_busy, wr_en;
    logic [4:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0] lq_count;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.LQ_DEPTH(D), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_ld_valid(iss_ld_valid), .iss_ld_rd(iss_ld_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .lq_count(lq_count)
    );

    int n_cmp = 0, n_bad = 0;

    // reference model: FIFO of {rd,data}, pending set, and the expected write of the next cycle
    logic [36:0] mq[$];
    logic [31:0] mpend = '0;
    logic        m_en = 0, m_ld = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;

    task automatic tick();
        bit rdy, byp;
        logic [36:0] e;
        if (rst) begin
            mq.delete();
            mpend = '0;
            m_en = 0; m_ld = 0; m_addr = 0; m_data = 0;
        end else begin
            rdy = mq.size() != D;
            if (m_en && m_ld) mpend[m_addr] = 1'b0;
            if (iss_ld_valid && iss_ld_rd != 0) mpend[iss_ld_rd] = 1'b1;
            byp = 0;
            if (alu_valid && alu_rd != 0) begin
                m_en = 1; m_ld = 0; m_addr = alu_rd; m_data = alu_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_en = 1; m_ld = 1; m_addr = e[36:32]; m_data = e[31:0];
            end else if (BYP && ld_valid && ld_rd != 0) begin
                m_en = 1; m_ld = 1; m_addr = ld_rd; m_data = ld_data; byp = 1;
            end else begin
                m_en = 0; m_ld = 0;
            end
            if (ld_valid && rdy && ld_rd != 0 && !byp) mq.push_back({ld_rd, ld_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; ld_valid = 0; iss_ld_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (wr_en !== 0 || wr_addr !== 0 || wr_data !== 0) begin
            n_bad++; $display("FAIL reset_wr: en=%0b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data);
        end
        n_cmp++;
        if (lq_count !== 0 || ld_ready !== 1) begin
            n_bad++; $display("FAIL reset_q: count=%0d ready=%0b want 0/1", lq_count, ld_ready);
        end
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r); rs2_addr = 5'(31 - r); #1;
            n_cmp++;
            if (rs1_busy !== 0 || rs2_busy !== 0) begin
                n_bad++; $display("FAIL reset_busy r%0d: %0b/%0b want 0/0", r, rs1_busy, rs2_busy);
            end
        end
    endtask

    task automatic test_alu();
        do_reset();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
        tick();
        idle();
        n_cmp++;
        if (wr_en !== 1 || wr_addr !== 3 || wr_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL alu_write: en=%0b addr=%0d data=%h want 1/3/deadbeef", wr_en, wr_addr, wr_data);
        end
        tick();
        n_cmp++;
        if (wr_en !== 0) begin
            n_bad++; $display("FAIL alu_single: en=%0b want 0", wr_en);
        end
    endtask

    task automatic test_load_use();
        int wk = 0, bk = 0;
        logic [31:0] wd = 0;
        do_reset();
        rs1_addr = 7; rs2_addr = 8;
        iss_ld_valid = 1; iss_ld_rd = 7;
        tick();
        idle();
        n_cmp++;
        if (rs1_busy !== 1 || rs2_busy !== 0) begin
            n_bad++; $display("FAIL lu_busy_set: rs1=%0b rs2=%0b want 1/0", rs1_busy, rs2_busy);
        end
        tick();
        ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
        tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            if (wk == 0 && wr_en && wr_addr == 7) begin wk = k; wd = wr_data; end
            if (bk == 0 && !rs1_busy) bk = k;
            tick();
        end
        n_cmp++;
        if (wk != (BYP ? 1 : 2) || wd !== 32'h1234) begin
            n_bad++; $display("FAIL lu_write: cycle+%0d data=%h want +%0d/1234", wk, wd, BYP ? 1 : 2);
        end
        n_cmp++;
        if (bk != (BYP ? 2 : 3)) begin
            n_bad++; $display("FAIL lu_busy_clear: cycle+%0d want +%0d", bk, BYP ? 2 : 3);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(1 + i); alu_data = $urandom;
            ld_valid = i < 5; ld_rd = 5'(10 + i); ld_data = 32'h100 + i;
            #1;
            if (ld_valid && ld_ready) acc++;
            tick();
        end
        idle();
        n_cmp++;
        if (acc != 4 || ld_ready !== 0 || lq_count !== 4) begin
            n_bad++; $display("FAIL bp_full: acc=%0d ready=%0b count=%0d want 4/0/4", acc, ld_ready, lq_count);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++;
            if (wr_en !== 1 || wr_addr !== 5'(10 + j) || wr_data !== 32'h100 + j) begin
                n_bad++; $display("FAIL bp_drain%0d: en=%0b addr=%0d data=%h want 1/%0d/%h", j, wr_en, wr_addr, wr_data, 10 + j, 32'h100 + j);
            end
        end
        tick();
        n_cmp++;
        if (wr_en !== 0 || lq_count !== 0) begin
            n_bad++; $display("FAIL bp_empty: en=%0b count=%0d want 0/0", wr_en, lq_count);
        end
    endtask

    task automatic test_x0();
        do_reset();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
        ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
        tick();
        ld_valid = 0; alu_rd = 0; alu_data = 32'hBAD;
        tick();
        idle();
        n_cmp++;
        if (wr_en !== 1 || wr_addr !== 9 || wr_data !== 32'h99) begin
            n_bad++; $display("FAIL x0_drain: en=%0b addr=%0d data=%h want 1/9/99", wr_en, wr_addr, wr_data);
        end
        ld_valid = 1; ld_rd = 0; ld_data = 32'h77;
        tick();
        idle();
        n_cmp++;
        if (wr_en !== 0 || lq_count !== 0) begin
            n_bad++; $display("FAIL x0_load: en=%0b count=%0d want 0/0", wr_en, lq_count);
        end
    endtask

    task automatic test_wrap();
        logic [36:0] sent[$], got[$];
        do_reset();
        for (int i = 0; i < 13; i++) begin
            ld_valid = i < 10; ld_rd = 5'(1 + i); ld_data = $urandom;
            if (ld_valid) sent.push_back({ld_rd, ld_data});
            tick();
            if (wr_en) got.push_back({wr_addr, wr_data});
            n_cmp++;
            if (lq_count > 1) begin
                n_bad++; $display("FAIL wrap_count%0d: count=%0d want <=1", i, lq_count);
            end
        end
        idle();
        n_cmp++;
        if (got.size() != 10) begin
            n_bad++; $display("FAIL wrap_num: writes=%0d want 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== sent[i]) begin
                n_bad++; $display("FAIL wrap_order%0d: got %h want %h", i, got[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        do_reset();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        iss_ld_valid = 1; iss_ld_rd = 20; tick();
        iss_ld_rd = 21; tick();
        iss_ld_valid = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_rd = 5'(20 + i); ld_data = 32'hA0 + i;
            tick();
        end
        idle();
        rs1_addr = 20; rs2_addr = 21; #1;
        n_cmp++;
        if (lq_count !== 3 || rs1_busy !== 1 || rs2_busy !== 1) begin
            n_bad++; $display("FAIL rm_pre: count=%0d busy=%0b%0b want 3/11", lq_count, rs1_busy, rs2_busy);
        end
        rst = 1; tick(); rst = 0;
        n_cmp++;
        if (lq_count !== 0 || wr_en !== 0 || rs1_busy !== 0 || rs2_busy !== 0) begin
            n_bad++; $display("FAIL rm_post: count=%0d en=%0b busy=%0b%0b want 0/0/00", lq_count, wr_en, rs1_busy, rs2_busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr_en) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++; $display("FAIL rm_stray: writes=%0d want 0", stray);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data = $urandom;
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_data = $urandom;
            iss_ld_rd = 5'($urandom_range(1, 31));
            iss_ld_valid = ($urandom_range(0, 2) == 0) && !mpend[iss_ld_rd];
            rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
            tick();
            n_cmp++;
            if (wr_en !== m_en || (m_en && (wr_addr !== m_addr || wr_data !== m_data))) begin
                n_bad++; $display("FAIL rnd_wr c%0d: %0b/%0d/%h want %0b/%0d/%h", c, wr_en, wr_addr, wr_data, m_en, m_addr, m_data);
            end
            n_cmp++;
            if (int'(lq_count) != mq.size() || ld_ready !== (mq.size() != D)) begin
                n_bad++; $display("FAIL rnd_q c%0d: count=%0d ready=%0b want %0d", c, lq_count, ld_ready, mq.size());
            end
            n_cmp++;
            if (rs1_busy !== mpend[rs1_addr] || rs2_busy !== mpend[rs2_addr]) begin
                n_bad++; $display("FAIL rnd_busy c%0d: %0b%0b want %0b%0b", c, rs1_busy, rs2_busy, mpend[rs1_addr], mpend[rs2_addr]);
            end
            n_cmp++;
            if (wr_en && wr_addr == 0) begin
                n_bad++; $display("FAIL rnd_x0 c%0d: write to x0 data=%h want none", c, wr_data);
            end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_use();
        test_backpressure();
        test_x0();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
